// File: rtl/serial_add_sub_if.sv
// Start/done request and result bus for the digit-serial adder/subtractor.
// The master drives the operation request; the slave returns status and sticky results.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_brw;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout_brw, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout_brw, overflow
  );

endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial N-bit adder/subtractor: one shared DIGIT-wide slice, LSB-first,
// registered carry between digits, start/done handshake with sticky results.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_add_sub_if.slave   bus
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] sum_dig;
  logic             carry_msb_in;
  logic             carry_out;
  logic [WIDTH-1:0] acc_shift;
  logic             last_digit;

  // Shared slice: subtract is a + ~b with the inverted borrow preloaded as carry.
  always_comb begin
    logic c;
    a_dig        = a_q[DIGIT-1:0];
    b_dig        = b_q[DIGIT-1:0] ^ {DIGIT{mode_q}};
    sum_dig      = '0;
    carry_msb_in = 1'b0;
    c            = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum_dig[i]   = a_dig[i] ^ b_dig[i] ^ c;
      carry_msb_in = c;
      c            = (a_dig[i] & b_dig[i]) | (a_dig[i] & c) | (b_dig[i] & c);
    end
    carry_out = c;
    acc_shift = WIDTH'({sum_dig, acc_q} >> DIGIT);
  end

  assign last_digit = (cnt_q == CNT_W'(N - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          carry_d = bus.cin ^ bus.mode;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = acc_shift;
          cout_d   = carry_out ^ mode_q;
          ovf_d    = carry_msb_in ^ carry_out;
        end else begin
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout_brw = cout_q;
  assign bus.overflow = ovf_q;

endmodule
